// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and defaults for the uart_cfg block.
//   - DEF_CLKS_PER_BIT : default clk cycles per bit (84 MHz / 84 = 1 Mbps)
//   - DEF_DATA_BITS    : default data bits per frame
//   - tx_state_t       : transmitter FSM states
//   - rx_state_t       : receiver FSM states
package uart_pkg;

    localparam int DEF_CLKS_PER_BIT = 84;
    localparam int DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
//   Down-counting bit timer. load restarts a bit period; while count is high
//   the counter runs down and reloads itself on terminal count, so full
//   strobes once every CLKS_PER_BIT cycles. mid strobes CLKS_PER_BIT/2 cycles
//   after a load.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   load  : restart the bit period (wins over count)
//   count : timer enable
//   mid   : mid-bit strobe
//   full  : end-of-bit strobe
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
)(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic mid,
    output logic full
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    // Counter value seen on cycle CLKS_PER_BIT/2 after a load.
    localparam logic [CW-1:0] MID_CNT  = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LAST_CNT;
        end else if (count) begin
            if (cnt == '0) begin
                cnt <= LAST_CNT;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign mid  = count && (cnt == MID_CNT);
    assign full = count && (cnt == '0);

endmodule

// File: rtl/uart_cfg.sv
// uart_cfg
//   Configurable UART transmitter and receiver sharing one clock but otherwise
//   independent. Optional parity bit is compiled in with `define UART_PARITY_EN.
//
//   TX FSM
//   state     | meaning
//   TX_IDLE   | tx high, tx_ready high, waiting for tx_valid
//   TX_START  | driving start bit (low)
//   TX_DATA   | driving data bits, LSB first
//   TX_PARITY | driving parity bit (UART_PARITY_EN only)
//   TX_STOP   | driving STOP_BITS stop bits (high)
//
//   RX FSM
//   state     | meaning
//   RX_IDLE   | waiting for synchronized rx low
//   RX_START  | confirming start bit at mid-bit, glitch returns to idle
//   RX_DATA   | sampling data bits mid-bit, LSB first
//   RX_PARITY | sampling parity bit (UART_PARITY_EN only)
//   RX_STOP   | sampling stop bit, publishing the word
//   RX_BREAK  | stop bit was low, waiting for line to return high
//
// Ports:
//   clk           : clock
//   rst_n         : synchronous active-low reset
//   tx_valid      : request to send tx_data
//   tx_data       : word to send
//   tx_ready      : transmitter idle, accepts tx_valid
//   tx            : serial out, idles high
//   rx            : asynchronous serial in
//   rx_data       : last received word
//   rx_valid      : one-cycle pulse when a frame completes
//   rx_frame_err  : stop bit of last frame sampled low
//   rx_parity_err : parity mismatch on last frame (0 without UART_PARITY_EN)
module uart_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 4095) begin : g_bad_clks_per_bit
        $error("uart_cfg: CLKS_PER_BIT must be 4..4095");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_cfg: PARITY_ODD must be 0 or 1");
    end

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    // ---------------------------------------------------------------- TX
    tx_state_t            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic [BCW-1:0]       tx_bit_q;
    logic                 tx_load;
    logic                 tx_full;
    logic                 tx_mid_unused;
`ifdef UART_PARITY_EN
    logic                 tx_par_q;
`endif

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tx_load),
        .count (tx_state_q != TX_IDLE),
        .mid   (tx_mid_unused),
        .full  (tx_full)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_load    = 1'b1;
                end
            end
            TX_START: begin
                if (tx_full) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                if (tx_full && tx_bit_q == LAST_DATA) begin
`ifdef UART_PARITY_EN
                    tx_state_d = TX_PARITY;
`else
                    tx_state_d = TX_STOP;
`endif
                end
            end
            TX_PARITY: begin
                if (tx_full) tx_state_d = TX_STOP;
            end
            TX_STOP: begin
                if (tx_full && tx_bit_q == LAST_STOP) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            if (tx_load) begin
                tx_shift_q <= tx_data;
                tx_bit_q   <= '0;
`ifdef UART_PARITY_EN
                tx_par_q   <= (^tx_data) ^ PARITY_ODD[0];
`endif
            end else if (tx_full && tx_state_q == TX_DATA) begin
                tx_shift_q <= tx_shift_q >> 1;
                // Cleared on the last data bit so it can count stop bits next.
                tx_bit_q   <= (tx_bit_q == LAST_DATA) ? '0 : tx_bit_q + 1'b1;
            end else if (tx_full && tx_state_q == TX_STOP) begin
                tx_bit_q   <= tx_bit_q + 1'b1;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (tx_state_q)
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = tx_shift_q[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx = tx_par_q;
`endif
            default:   tx = 1'b1;
        endcase
    end

    assign tx_ready = (tx_state_q == TX_IDLE);

    // ---------------------------------------------------------------- RX
    rx_state_t            rx_state_q, rx_state_d;
    logic [2:0]           rx_sync_q;
    logic                 rx_s;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic [BCW-1:0]       rx_bit_q;
    logic                 rx_load;
    logic                 rx_count;
    logic                 rx_mid;
    logic                 rx_full;
`ifdef UART_PARITY_EN
    logic                 rx_par_q;
    logic                 rx_par_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sync_q <= 3'b111;
        end else begin
            rx_sync_q <= {rx_sync_q[1:0], rx};
        end
    end

    assign rx_s     = rx_sync_q[2];
    assign rx_count = (rx_state_q != RX_IDLE) && (rx_state_q != RX_BREAK);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (rx_load),
        .count (rx_count),
        .mid   (rx_mid),
        .full  (rx_full)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_load    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_d = RX_START;
                    rx_load    = 1'b1;
                end
            end
            RX_START: begin
                // Reloading at mid-start puts every later sample mid-bit.
                if (rx_mid) begin
                    if (rx_s) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_load    = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_full && rx_bit_q == LAST_DATA) begin
`ifdef UART_PARITY_EN
                    rx_state_d = RX_PARITY;
`else
                    rx_state_d = RX_STOP;
`endif
                end
            end
            RX_PARITY: begin
                if (rx_full) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                if (rx_full) rx_state_d = rx_s ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: begin
                if (rx_s) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q   <= RX_IDLE;
            rx_shift_q   <= '0;
            rx_bit_q     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q     <= 1'b0;
            rx_par_err_q <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            rx_valid   <= 1'b0;
            if (rx_state_q == RX_START && rx_mid) begin
                rx_bit_q <= '0;
            end
            if (rx_state_q == RX_DATA && rx_full) begin
                rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
                rx_bit_q   <= rx_bit_q + 1'b1;
            end
`ifdef UART_PARITY_EN
            if (rx_state_q == RX_PARITY && rx_full) begin
                rx_par_q <= rx_s;
            end
`endif
            if (rx_state_q == RX_STOP && rx_full) begin
                rx_data      <= rx_shift_q;
                rx_valid     <= 1'b1;
                rx_frame_err <= ~rx_s;
`ifdef UART_PARITY_EN
                rx_par_err_q <= rx_par_q ^ (^rx_shift_q) ^ PARITY_ODD[0];
`endif
            end
        end
    end

`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_par_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
